pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline register chain (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Decides per cycle whether the front end stalls, whether a bubble goes into ID/EX, and when all stage registers take the interrupt flush (`int_clr`).
- Owns the multiply/divide busy counter and a stall-cycle performance counter.
- Sits beside the datapath; its outputs drive the enable/clear inputs of every stage register and the PC.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issues from E.
- DIV_CYCLES, 10, busy cycles after a div/divu issues from E.
- CNT_W, 4, width of the MDU countdown; must hold DIV_CYCLES.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- d_rs  in  5  D-stage rs number.
- d_rt  in  5  D-stage rt number.
- d_tuse_rs  in  2  cycles until D needs rs; 3 = not used.
- d_tuse_rt  in  2  cycles until D needs rt; 3 = not used.
- d_md_use  in  1  D instruction is mfhi/mflo/mthi/mtlo/mult/div.
- e_wa  in  5  E-stage destination register.
- e_tnew  in  2  cycles until E result is ready.
- m_wa  in  5  M-stage destination register.
- m_tnew  in  2  cycles until M result is ready.
- e_md_start  in  1  E holds a mult/div issuing this cycle.
- e_md_div  in  1  qualifies e_md_start: 1 = div, 0 = mult.
- int_req  in  1  CP0 interrupt/exception request.
- en_f  out  1  PC enable.
- en_d  out  1  IF/ID enable.
- clr_e  out  1  synchronous clear of ID/EX (bubble).
- int_clr  out  1  flush of ID/EX, EX/MEM, MEM/WB.
- md_busy  out  1  MDU counting.
- stall_cycles  out  32  count of cycles with en_d = 0.

Behaviour:
- Reset (reset=0 at a clk edge) clears md_cnt, md_busy, stall_cycles and the FSM (IDLE).
- While reset is low, the combinational outputs are: en_f=0, en_d=0, clr_e=1, int_clr=0.
- Data hazard stall, raw_stall (combinational). It is 1 if either condition holds:
  - e_wa≠0 and (d_rs==e_wa with e_tnew>d_tuse_rs, or d_rt==e_wa with e_tnew>d_tuse_rt);
  - the same test against m_wa/m_tnew.
  - Register 0 never stalls.
  - A Tuse of 3 never matches.
- MDU stall, md_stall = d_md_use & (md_busy | e_md_start).
- stall = raw_stall | md_stall. Outputs: en_f = en_d = ~stall; clr_e = stall.
- MDU counter:
  - When e_md_start=1 and no flush is in effect, md_cnt loads DIV_CYCLES or MULT_CYCLES (per e_md_div) and md_busy=1 from the next cycle.
  - Each later cycle decrements md_cnt. md_busy drops in the cycle after md_cnt reaches 1, giving exactly N busy cycles.
  - e_md_start while md_busy=1 cannot occur, because md_stall prevents it. If it does occur, the counter reloads.
- Interrupt FSM has two states, IDLE and FLUSH.
  - IDLE → FLUSH when int_req=1. int_clr=1 combinationally in that same cycle.
  - In FLUSH, int_clr=0 and int_req is ignored; next state is IDLE, giving one flush per request edge window.
  - Held int_req therefore produces int_clr pulses every other cycle.
  - When int_clr=1: en_f=1, en_d=1, clr_e=0, because the flush overrides stall. The PC redirect comes from CP0.
  - An MDU operation already counting continues; e_md_start is ignored in the flush cycle.
- stall_cycles increments (wrapping at 2^32) on every non-reset cycle with en_d=0.
- Simultaneous int_req and raw_stall: the flush wins and stall_cycles does not increment.
- Reset mid-MDU: md_busy=0 on the next cycle.

Decomposition:
- Shared package holds:
  - TUSE_NONE = 2'd3;
  - FSM state encodings IDLE/FLUSH;
  - MULT/DIV cycle defaults;
  - register-0 constant.
- One sub-module, md_busy_counter: the load/decrement/busy logic.
- The hazard compare and the FSM stay in the top module.

Test Plan:
- lw $2 in E (e_wa=2, e_tnew=2), D reads $2 with d_tuse_rs=1 → en_f=en_d=0, clr_e=1. Drop e_tnew to 1 → no stall. stall_cycles=1.
- d_rs=0, e_wa=0, e_tnew=2, d_tuse_rs=0 → no stall.
- e_md_start=1, e_md_div=0 → md_busy high for exactly 5 cycles. With d_md_use=1 throughout, en_d=0 for 6 cycles (issue cycle plus 5).
- e_md_start=1, e_md_div=1 → md_busy for exactly 10 cycles. Assert reset=0 at busy cycle 4 → md_busy=0 next cycle and stall_cycles=0.
- int_req held 4 cycles while raw_stall=1 → int_clr pattern 1,0,1,0 with en_d=1 in the int_clr cycles. stall_cycles increments only in the non-flush cycles (+2).
- int_req=1 together with e_md_start=1 → int_clr=1 and md_busy stays 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants, state encodings and the hazard-compare helper for the
// pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  // Tuse value meaning "this operand is not read by the D-stage instruction".
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Register $0 is hard-wired to zero and can never be a hazard source.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Default multiply/divide unit latencies, counted from the issue cycle in E.
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Interrupt flush sequencer states.
  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } int_state_e;

  // True when a D-stage source operand needs a value that a later stage
  // will not have ready in time.
  function automatic logic raw_hit(input logic [4:0] src,
                                   input logic [1:0] tuse,
                                   input logic [4:0] wa,
                                   input logic [1:0] tnew);
    return (wa != REG_ZERO) && (tuse != TUSE_NONE) &&
           (src == wa) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard inputs from the datapath and the enable/clear controls
// that go back to the stage registers.
interface pipe_hazard_ctrl_if;

  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [1:0]  d_tuse_rs;
  logic [1:0]  d_tuse_rt;
  logic        d_md_use;
  logic [4:0]  e_wa;
  logic [1:0]  e_tnew;
  logic [4:0]  m_wa;
  logic [1:0]  m_tnew;
  logic        e_md_start;
  logic        e_md_div;
  logic        int_req;

  logic        en_f;
  logic        en_d;
  logic        clr_e;
  logic        int_clr;
  logic        md_busy;
  logic [31:0] stall_cycles;

  // Datapath side: reports pipeline state, consumes the controls.
  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_md_use,
           e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_div, int_req,
    input  en_f, en_d, clr_e, int_clr, md_busy, stall_cycles
  );

  // Controller side.
  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_md_use,
           e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_div, int_req,
    output en_f, en_d, clr_e, int_clr, md_busy, stall_cycles
  );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// Multiply/divide busy countdown: loads the operation latency on issue and
// holds busy high for exactly that many following cycles.
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  logic [CNT_W-1:0] md_cnt;

  // Load on issue, count down while busy, release after the last count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      md_cnt <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      md_cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      busy   <= 1'b1;
    end else if (busy) begin
      if (md_cnt == CNT_W'(1)) begin
        md_cnt <= '0;
        busy   <= 1'b0;
      end else begin
        md_cnt <= md_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard sequencer: data-hazard and MDU stalls, interrupt flush
// pulses, and a count of front-end stall cycles.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  int_state_e state, state_nxt;
  logic       raw_stall;
  logic       md_stall;
  logic       stall;
  logic       int_clr;
  logic       en_d;

  // Operand readiness check against the E and M stage producers.
  always_comb begin
    raw_stall = raw_hit(bus.d_rs, bus.d_tuse_rs, bus.e_wa, bus.e_tnew) |
                raw_hit(bus.d_rt, bus.d_tuse_rt, bus.e_wa, bus.e_tnew) |
                raw_hit(bus.d_rs, bus.d_tuse_rs, bus.m_wa, bus.m_tnew) |
                raw_hit(bus.d_rt, bus.d_tuse_rt, bus.m_wa, bus.m_tnew);
    md_stall  = bus.d_md_use & (bus.md_busy | bus.e_md_start);
    stall     = raw_stall | md_stall;
  end

  // Flush sequencer next state and the stage-register controls; the flush
  // overrides any stall, and reset holds the front end.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_nxt    = state;
    int_clr      = 1'b0;
    en_d         = 1'b0;
    bus.en_f     = 1'b0;
    bus.clr_e    = 1'b1;
    if (reset) begin
      unique case (state)
        IDLE: begin
          if (bus.int_req) begin
            int_clr   = 1'b1;
            state_nxt = FLUSH;
          end
        end
        FLUSH: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
      if (int_clr) begin
        en_d      = 1'b1;
        bus.en_f  = 1'b1;
        bus.clr_e = 1'b0;
      end else begin
        en_d      = ~stall;
        bus.en_f  = ~stall;
        bus.clr_e = stall;
      end
    end
  end

  assign bus.int_clr = int_clr;
  assign bus.en_d    = en_d;

  // Flush sequencer state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stall-cycle performance counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!reset)     bus.stall_cycles <= '0;
    else if (!en_d) bus.stall_cycles <= bus.stall_cycles + 32'd1;
  end

  // A new MDU operation is not accepted in a flush cycle.
  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (bus.e_md_start & ~int_clr),
    .is_div (bus.e_md_div),
    .busy   (bus.md_busy)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the stimulus process drives one
// vector per cycle and queues the hand-computed response; a monitor samples
// the outputs at the falling edge and compares against the queue head.
module tb_pipe_hazard_ctrl;

  typedef struct {
    string       name;
    logic        en_f;
    logic        en_d;
    logic        clr_e;
    logic        int_clr;
    logic        md_busy;
    logic [31:0] stall_cycles;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.d_rs       = 5'd0;
    bus.d_rt       = 5'd0;
    bus.d_tuse_rs  = 2'd3;
    bus.d_tuse_rt  = 2'd3;
    bus.d_md_use   = 1'b0;
    bus.e_wa       = 5'd0;
    bus.e_tnew     = 2'd0;
    bus.m_wa       = 5'd0;
    bus.m_tnew     = 2'd0;
    bus.e_md_start = 1'b0;
    bus.e_md_div   = 1'b0;
    bus.int_req    = 1'b0;
  endtask

  // Queue the expected response for the current cycle, then move to the
  // next cycle (inputs change 1 time unit after the rising edge).
  task automatic expect_cycle(input string name, input logic ef, input logic ed,
                              input logic ce, input logic ic, input logic mb,
                              input logic [31:0] sc);
    exp_t e;
    e.name = name; e.en_f = ef; e.en_d = ed; e.clr_e = ce;
    e.int_clr = ic; e.md_busy = mb; e.stall_cycles = sc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", name, field, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare whenever an
  // expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp(e.name, "en_f",         {31'd0, bus.en_f},    {31'd0, e.en_f});
        cmp(e.name, "en_d",         {31'd0, bus.en_d},    {31'd0, e.en_d});
        cmp(e.name, "clr_e",        {31'd0, bus.clr_e},   {31'd0, e.clr_e});
        cmp(e.name, "int_clr",      {31'd0, bus.int_clr}, {31'd0, e.int_clr});
        cmp(e.name, "md_busy",      {31'd0, bus.md_busy}, {31'd0, e.md_busy});
        cmp(e.name, "stall_cycles", bus.stall_cycles,     e.stall_cycles);
      end
    end
  end

  // Stimulus with hand-computed responses.
  initial begin
    reset = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;

    // Reset holds the front end and suppresses the flush.
    bus.int_req = 1'b1;
    expect_cycle("reset_hold", 0, 0, 1, 0, 0, 0);

    reset = 1'b1;
    idle_inputs();
    expect_cycle("idle", 1, 1, 0, 0, 0, 0);

    // lw $2 in E, D reads $2 next cycle.
    bus.e_wa = 5'd2; bus.e_tnew = 2'd2; bus.d_rs = 5'd2; bus.d_tuse_rs = 2'd1;
    expect_cycle("lw_use_e", 0, 0, 1, 0, 0, 0);
    bus.e_tnew = 2'd1;
    expect_cycle("lw_ready", 1, 1, 0, 0, 0, 1);

    // rt hazard against M.
    idle_inputs();
    bus.m_wa = 5'd7; bus.m_tnew = 2'd1; bus.d_rt = 5'd7; bus.d_tuse_rt = 2'd0;
    expect_cycle("rt_m_stall", 0, 0, 1, 0, 0, 1);

    // Operand not used never stalls.
    bus.m_tnew = 2'd3; bus.d_tuse_rt = 2'd3;
    expect_cycle("tuse_none", 1, 1, 0, 0, 0, 2);

    // Register 0 never stalls.
    idle_inputs();
    bus.e_wa = 5'd0; bus.e_tnew = 2'd2; bus.d_rs = 5'd0; bus.d_tuse_rs = 2'd0;
    expect_cycle("reg_zero", 1, 1, 0, 0, 0, 2);

    // Tnew equal to Tuse is in time.
    bus.e_wa = 5'd3; bus.e_tnew = 2'd1; bus.d_rs = 5'd3; bus.d_tuse_rs = 2'd1;
    expect_cycle("tnew_eq_tuse", 1, 1, 0, 0, 0, 2);

    // mult issue with a dependent MDU instruction in D: 6 stalled cycles.
    idle_inputs();
    bus.e_md_start = 1'b1; bus.e_md_div = 1'b0; bus.d_md_use = 1'b1;
    expect_cycle("mult_issue", 0, 0, 1, 0, 0, 2);
    bus.e_md_start = 1'b0;
    for (int i = 0; i < 5; i++)
      expect_cycle($sformatf("mult_busy%0d", i + 1), 0, 0, 1, 0, 1, 32'(3 + i));
    expect_cycle("mult_done", 1, 1, 0, 0, 0, 8);

    // div issue, then reset during the fourth busy cycle.
    idle_inputs();
    bus.e_md_start = 1'b1; bus.e_md_div = 1'b1;
    expect_cycle("div_issue", 1, 1, 0, 0, 0, 8);
    bus.e_md_start = 1'b0;
    for (int i = 0; i < 3; i++)
      expect_cycle($sformatf("div_busy%0d", i + 1), 1, 1, 0, 0, 1, 8);
    reset = 1'b0;
    expect_cycle("div_busy4_reset", 0, 0, 1, 0, 1, 8);
    reset = 1'b1;
    expect_cycle("after_reset", 1, 1, 0, 0, 0, 0);

    // Held interrupt over a data hazard: flush every other cycle.
    bus.int_req = 1'b1;
    bus.e_wa = 5'd2; bus.e_tnew = 2'd2; bus.d_rs = 5'd2; bus.d_tuse_rs = 2'd1;
    expect_cycle("int_flush1", 1, 1, 0, 1, 0, 0);
    expect_cycle("int_gap1",   0, 0, 1, 0, 0, 0);
    expect_cycle("int_flush2", 1, 1, 0, 1, 0, 1);
    expect_cycle("int_gap2",   0, 0, 1, 0, 0, 1);
    idle_inputs();
    expect_cycle("int_after",  1, 1, 0, 0, 0, 2);

    // MDU issue in a flush cycle is dropped.
    bus.int_req = 1'b1; bus.e_md_start = 1'b1;
    expect_cycle("int_md_flush", 1, 1, 0, 1, 0, 2);
    idle_inputs();
    expect_cycle("int_md_gap",   1, 1, 0, 0, 0, 2);
    expect_cycle("int_md_idle",  1, 1, 0, 0, 0, 2);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
